fc_weight_loader: RTL and testbench

Run-time weight writer for the fully connected layer. It accepts one weight word per valid/ready handshake and stores it into an internal synchronous RAM of depth M*N/P. It exposes a one-cycle-latency read port that is drop-in compatible with the constant weight ROM read interface (addr in, registered signed z out). It replaces the hard-coded ROM contents with weights loaded by the host before inference starts.

---
 rtl/fc_pkg.sv | 21 ++
 rtl/fc_weight_loader_if.sv | 28 ++
 rtl/weight_ram_1w1r.sv | 51 +++++
 rtl/fc_weight_loader.sv | 121 ++++++++++++
 tb/tb_fc_weight_loader.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared sizing helpers and loader state type for the FC weight path
package fc_pkg;

  // Number of weight words held for an MxN layer read P words at a time.
  function automatic int calc_depth(input int m, input int n, input int p);
    return (m * n) / p;
  endfunction

  // Address width for calc_depth words; never narrower than one bit.
  function automatic int calc_aw(input int m, input int n, input int p);
    int d;
    d = calc_depth(m, n, p);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    DONE = 1'b1
  } ld_state_e;

endpackage

// File: rtl/fc_weight_loader_if.sv
// rtl/fc_weight_loader_if.sv - weight load stream, read port and status bundle
interface fc_weight_loader_if #(
  parameter int T  = 16,
  parameter int AW = 6
);

  logic                reload;
  logic                w_valid;
  logic                w_ready;
  logic signed [T-1:0] w_data;
  logic                load_done;
  logic [AW-1:0]       rd_addr;
  logic signed [T-1:0] rd_data;
  logic [T+AW-1:0]     checksum;

  // Host / consumer side.
  modport master (
    output reload, w_valid, w_data, rd_addr,
    input  w_ready, load_done, rd_data, checksum
  );

  // Loader side.
  modport slave (
    input  reload, w_valid, w_data, rd_addr,
    output w_ready, load_done, rd_data, checksum
  );

endinterface

// File: rtl/weight_ram_1w1r.sv
// rtl/weight_ram_1w1r.sv - DEPTH x T RAM, one sync write port, one registered read port
module weight_ram_1w1r #(
  parameter int DEPTH = 48,
  parameter int T     = 16,
  parameter int AW    = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic signed [T-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic signed [T-1:0] rdata_o
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic signed [T-1:0] mem [DEPTH];
  logic signed [T-1:0] rdata_q;
  logic signed [T-1:0] rdata_d;
  logic                raddr_ok;

  assign raddr_ok = ({1'b0, raddr_i} < DEPTH_W);

  // Read mux: addresses past the last word read as zero.
  always_comb begin
    rdata_d = '0;
    if (raddr_ok) begin
      rdata_d = mem[raddr_i];
    end
  end

  // Storage array is not reset; the loader overwrites every word before use.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read data; sampling before the write lands gives read-before-write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fc_weight_loader.sv
// rtl/fc_weight_loader.sv - run-time weight loader replacing the FC weight ROM; optional FC_WEIGHT_CHECKSUM_EN
module fc_weight_loader
  import fc_pkg::*;
#(
  parameter int M = 6,
  parameter int N = 8,
  parameter int T = 16,
  parameter int P = 1,
  localparam int DEPTH = calc_depth(M, N, P),
  localparam int AW    = calc_aw(M, N, P)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  fc_weight_loader_if.slave bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam int            CW        = T + AW;

  ld_state_e     state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          load_done_q, load_done_d;
  logic          w_ready;
  logic          wr_en;

  assign w_ready = (state_q == LOAD) && !bus.reload;

  // Next state, write address and write strobe.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_en     = 1'b0;
    case (state_q)
      LOAD: begin
        if (bus.reload) begin
          wr_addr_d = '0;
        end else if (bus.w_valid) begin
          wr_en = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            state_d   = DONE;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      DONE: begin
        if (bus.reload) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end
      end
      default: begin
        state_d   = LOAD;
        wr_addr_d = '0;
      end
    endcase
    load_done_d = (state_d == DONE);
  end

  // State, write pointer and done flag registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= LOAD;
      wr_addr_q   <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      load_done_q <= load_done_d;
    end
  end

`ifdef FC_WEIGHT_CHECKSUM_EN
  logic [CW-1:0] checksum_q, checksum_d;
  logic [CW-1:0] w_ext;

  assign w_ext = {{AW{bus.w_data[T-1]}}, bus.w_data};

  // Wrapping sum of every accepted word; reload starts a new sum.
  always_comb begin
    checksum_d = checksum_q;
    if (bus.reload) begin
      checksum_d = '0;
    end else if (wr_en) begin
      checksum_d = checksum_q + w_ext;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = {CW{1'b0}};
`endif

  weight_ram_1w1r #(
    .DEPTH (DEPTH),
    .T     (T),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .we_i    (wr_en),
    .waddr_i (wr_addr_q),
    .wdata_i (bus.w_data),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.w_ready   = w_ready;
  assign bus.load_done = load_done_q;

endmodule

// File: tb/tb_fc_weight_loader.sv
// tb/tb_fc_weight_loader.sv - directed self-checking bench for fc_weight_loader
module tb_fc_weight_loader;

`ifdef FC_WEIGHT_CHECKSUM_EN
  localparam int CS_ON = 1;
`else
  localparam int CS_ON = 0;
`endif

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  fc_weight_loader_if #(.T(16), .AW(6)) bus ();

  fc_weight_loader #(.M(6), .N(8), .T(16), .P(1)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int v);
    bus.w_valid = 1'b1;
    bus.w_data  = 16'(v);
    step();
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [15:0] exp);
    bus.w_valid = 1'b0;
    bus.rd_addr = 6'(a);
    step();
    chk(tag, {16'h0, bus.rd_data}, {16'h0, exp});
  endtask

  task automatic pulse_reload();
    bus.w_valid = 1'b0;
    bus.reload  = 1'b1;
    step();
    bus.reload  = 1'b0;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.reload  = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.rd_addr = '0;
    step();
    step();
    chk("rst_load_done", {31'h0, bus.load_done}, 32'd0);
    chk("rst_w_ready",   {31'h0, bus.w_ready},   32'd1);
    chk("rst_rd_data",   {16'h0, bus.rd_data},   32'd0);
    chk("rst_checksum",  {10'h0, bus.checksum},  32'd0);
    reset = 1'b0;

    // Back-to-back load of 0..47.
    for (int i = 0; i < 48; i++) begin
      put(i);
      if (i == 46) chk("seq_done_early", {31'h0, bus.load_done}, 32'd0);
    end
    chk("seq_done", {31'h0, bus.load_done}, 32'd1);
    chk("seq_checksum", {10'h0, bus.checksum}, (CS_ON != 0) ? 32'd1128 : 32'd0);
    for (int a = 0; a < 48; a++) rd_chk("seq_read", a, 16'(a));

    // DONE ignores w_valid; reload restarts at address 0.
    bus.w_valid = 1'b1;
    bus.w_data  = 16'd777;
    #1;
    chk("done_w_ready", {31'h0, bus.w_ready}, 32'd0);
    step();
    step();
    rd_chk("done_mem0", 0, 16'd0);
    rd_chk("done_mem47", 47, 16'd47);
    pulse_reload();
    chk("rl_load_done", {31'h0, bus.load_done}, 32'd0);
    chk("rl_w_ready",   {31'h0, bus.w_ready},   32'd1);
    chk("rl_checksum",  {10'h0, bus.checksum},  32'd0);
    put(500);
    rd_chk("rl_first_word", 0, 16'd500);
    chk("rl_checksum_1", {10'h0, bus.checksum}, (CS_ON != 0) ? 32'd500 : 32'd0);

    // -1 words with w_valid toggling.
    pulse_reload();
    bus.w_data = 16'hFFFF;
    for (int k = 0; k < 96; k++) begin
      bus.w_valid = (k % 2 == 0);
      step();
      if (k == 93) chk("tog_done_early", {31'h0, bus.load_done}, 32'd0);
      if (k == 94) chk("tog_done", {31'h0, bus.load_done}, 32'd1);
    end
    chk("tog_checksum", {10'h0, bus.checksum}, (CS_ON != 0) ? 32'h3FFFD0 : 32'd0);
    rd_chk("tog_mem0", 0, 16'hFFFF);
    rd_chk("tog_mem47", 47, 16'hFFFF);

    // Reload after 20 words: the reload cycle writes nothing.
    pulse_reload();
    for (int i = 0; i < 20; i++) put(200 + i);
    bus.reload  = 1'b1;
    bus.w_valid = 1'b1;
    bus.w_data  = 16'd1234;
    #1;
    chk("mid_rl_w_ready", {31'h0, bus.w_ready}, 32'd0);
    step();
    bus.reload = 1'b0;
    rd_chk("mid_rl_no_write", 20, 16'hFFFF);
    rd_chk("mid_rl_stale", 19, 16'd219);
    for (int i = 0; i < 48; i++) begin
      put(300 + i);
      if (i == 46) chk("mid_rl_done_early", {31'h0, bus.load_done}, 32'd0);
    end
    chk("mid_rl_done", {31'h0, bus.load_done}, 32'd1);
    rd_chk("mid_rl_addr0", 0, 16'd300);
    rd_chk("mid_rl_addr20", 20, 16'd320);
    chk("mid_rl_checksum", {10'h0, bus.checksum}, (CS_ON != 0) ? 32'd15528 : 32'd0);

    // Reset in the middle of a load.
    pulse_reload();
    for (int i = 0; i < 30; i++) put(7);
    rd_chk("pre_rst_rd", 0, 16'd7);
    reset = 1'b1;
    #1;
    chk("rst_mid_load_done", {31'h0, bus.load_done}, 32'd0);
    chk("rst_mid_rd_data",   {16'h0, bus.rd_data},   32'd0);
    chk("rst_mid_checksum",  {10'h0, bus.checksum},  32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 48; i++) begin
      put(9);
      if (i == 46) chk("post_rst_done_early", {31'h0, bus.load_done}, 32'd0);
    end
    chk("post_rst_done", {31'h0, bus.load_done}, 32'd1);
    rd_chk("post_rst_addr47", 47, 16'd9);

    // Same-address read and write: old data first, new data next cycle.
    pulse_reload();
    for (int i = 0; i < 5; i++) put(i + 1);
    bus.rd_addr = 6'd5;
    put(99);
    chk("rbw_old", {16'h0, bus.rd_data}, 32'd9);
    bus.w_valid = 1'b0;
    step();
    chk("rbw_new", {16'h0, bus.rd_data}, 32'd99);

    // Addresses beyond the last word read as zero.
    rd_chk("oor_48", 48, 16'd0);
    rd_chk("oor_63", 63, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
